// File: rtl/sa_nd_mac.sv
// Output-stationary N x N integer systolic MAC array computing C = A*B over a streamed inner dimension.
// Latency: k_len + 2N-2 cycles from first accepted beat to first out_vld when unstalled.
// Backpressure: operand beats only advance the array on a_vld & a_rdy; drain holds out_data while out_rdy is low.
module sa_nd_mac #(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int AW = 32,
  parameter int KW = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            signed_mode,
  input  logic            a_vld,
  output logic            a_rdy,
  input  logic [N*DW-1:0] a_data,
  input  logic [N*DW-1:0] b_data,
  output logic            busy,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [AW-1:0]   out_data,
  output logic            done
);

  localparam int NN = N * N;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int FW = $clog2(2 * N) + 1;
  localparam int PW = 2 * DW + 2;
  localparam int EW = (AW > PW) ? AW : PW;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t        state;
  logic [KW-1:0] klen_q;
  logic [KW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic [IW-1:0] idx;
  logic          sm_q;
  logic          done_q;

  logic          en;
  logic          clr;
  logic [DW-1:0] a_src [N];
  logic [DW-1:0] b_src [N];
  logic [DW-1:0] a_in  [N][N];
  logic [DW-1:0] b_in  [N][N];
  logic [AW-1:0] acc_w [NN];

  // Product of two extended operands, sign-extended into the accumulator width (wraps modulo 2^AW).
  function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                            input logic sm);
    logic signed [DW:0]    ex;
    logic signed [DW:0]    ey;
    logic signed [PW-1:0]  p;
    logic signed [EW-1:0]  pe;
    ex = {sm & x[DW-1], x};
    ey = {sm & y[DW-1], y};
    p  = PW'(ex) * PW'(ey);
    pe = EW'(p);
    return pe[AW-1:0];
  endfunction

  assign clr      = (state == IDLE) && start;
  assign en       = ((state == LOAD) && a_vld) || (state == FLUSH);
  assign a_rdy    = (state == LOAD);
  assign busy     = (state != IDLE);
  assign out_vld  = (state == DRAIN);
  assign out_data = (state == DRAIN) ? acc_w[idx] : '0;
  assign done     = done_q;

  // Edge operands: stream data while loading, zeros are injected during flush.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_src[i] = (state == LOAD) ? a_data[i*DW +: DW] : '0;
      b_src[i] = (state == LOAD) ? b_data[i*DW +: DW] : '0;
    end
  end

  // Job control: accept start, count beats, run the flush window, then walk the results row-major.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      klen_q    <= '0;
      sm_q      <= 1'b0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      idx       <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            klen_q    <= k_len;
            sm_q      <= signed_mode;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            idx       <= '0;
            state     <= (k_len == '0) ? DRAIN : LOAD;
          end
        end
        LOAD: begin
          if (a_vld) begin
            if (beat_cnt == klen_q - KW'(1)) begin
              beat_cnt <= '0;
              state    <= (N == 1) ? DRAIN : FLUSH;
            end else begin
              beat_cnt <= beat_cnt + KW'(1);
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FW'(2 * N - 3)) begin
            flush_cnt <= '0;
            state     <= DRAIN;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DRAIN: begin
          if (out_rdy) begin
            if (idx == IW'(NN - 1)) begin
              idx    <= '0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_in[0][0] = a_src[0];
      assign b_in[0][0] = b_src[0];
    end else begin : g_chain
      logic [DW-1:0] ska [gi];
      logic [DW-1:0] skb [gi];
      // Delay row gi of A and column gi of B by gi enabled cycles so beats meet on the diagonal wave.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int s = 0; s < gi; s++) begin
            ska[s] <= '0;
            skb[s] <= '0;
          end
        end else if (clr) begin
          for (int s = 0; s < gi; s++) begin
            ska[s] <= '0;
            skb[s] <= '0;
          end
        end else if (en) begin
          ska[0] <= a_src[gi];
          skb[0] <= b_src[gi];
          for (int s = 1; s < gi; s++) begin
            ska[s] <= ska[s-1];
            skb[s] <= skb[s-1];
          end
        end
      end
      assign a_in[gi][0] = ska[gi-1];
      assign b_in[0][gi] = skb[gi-1];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [AW-1:0] acc;
      // Accumulate the operand pair currently passing through this PE.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)   acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= acc + mul_ext(a_in[gi][gj], b_in[gi][gj], sm_q);
      end
      assign acc_w[gi*N + gj] = acc;

      if (gj < N - 1) begin : g_ahop
        logic [DW-1:0] ah;
        // Forward the A operand one column to the right.
        always_ff @(posedge CLK or negedge RST_N) begin
          if (!RST_N)   ah <= '0;
          else if (clr) ah <= '0;
          else if (en)  ah <= a_in[gi][gj];
        end
        assign a_in[gi][gj+1] = ah;
      end

      if (gi < N - 1) begin : g_bhop
        logic [DW-1:0] bh;
        // Forward the B operand one row down.
        always_ff @(posedge CLK or negedge RST_N) begin
          if (!RST_N)   bh <= '0;
          else if (clr) bh <= '0;
          else if (en)  bh <= b_in[gi][gj];
        end
        assign b_in[gi+1][gj] = bh;
      end
    end
  end

endmodule

// File: tb/tb_sa_nd_mac.sv
// Self-checking bench for sa_nd_mac: directed scenarios plus randomized jobs against a matrix-product model.
// Runs a 32-bit and a 16-bit accumulator instance side by side on the same stimulus.
// Output stalls and operand bubbles are injected by the job driver.
module tb_sa_nd_mac;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int KW = 8;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b1;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            signed_mode = 1'b0;
  logic            a_vld = 1'b0;
  logic [N*DW-1:0] a_data = '0;
  logic [N*DW-1:0] b_data = '0;
  logic            out_rdy = 1'b0;
  logic            a_rdy, busy, out_vld, done;
  logic [31:0]     out_data;
  logic            a_rdy16, busy16, out_vld16, done16;
  logic [15:0]     out_data16;

  always #5 CLK = ~CLK;

  sa_nd_mac #(.N(N), .DW(DW), .AW(32), .KW(KW)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .a_vld(a_vld), .a_rdy(a_rdy), .a_data(a_data), .b_data(b_data), .busy(busy),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .done(done));

  sa_nd_mac #(.N(N), .DW(DW), .AW(16), .KW(KW)) dut16 (
    .CLK(CLK), .RST_N(RST_N), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .a_vld(a_vld), .a_rdy(a_rdy16), .a_data(a_data), .b_data(b_data), .busy(busy16),
    .out_vld(out_vld16), .out_rdy(out_rdy), .out_data(out_data16), .done(done16));

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  ga [16][N];
  logic [7:0]  gb [16][N];
  logic [31:0] res_q [$];
  logic [15:0] res16_q [$];
  int first_beat_cyc, first_vld_cyc, stall_err, done_cnt;
  bit busy_at_done, vld_at_done, a_rdy_seen, busy_seen, timed_out, done_next;

  // Reference: C[i][j] = sum_k ext(A[i][k]) * ext(B[k][j]) mod 2^aw.
  function automatic longint model(input int i, input int j, input int kl, input bit sm, input int aw);
    longint s = 0;
    longint x, y;
    for (int k = 0; k < kl; k++) begin
      x = sm ? longint'($signed(ga[k][i])) : longint'(ga[k][i]);
      y = sm ? longint'($signed(gb[k][j])) : longint'(gb[k][j]);
      s += x * y;
    end
    return s & ((longint'(1) << aw) - 1);
  endfunction

  task automatic load_scn1();
    ga[0][0] = 8'd1; ga[0][1] = 8'd3; gb[0][0] = 8'd5; gb[0][1] = 8'd6;
    ga[1][0] = 8'd2; ga[1][1] = 8'd4; gb[1][0] = 8'd7; gb[1][1] = 8'd8;
  endtask

  // Drives one job start-to-done and records what the DUTs produced.
  task automatic do_job(input int kl, input bit sm, input bit gaps, input int stall_at,
                        input int stall_len, input bit poke);
    int cyc = 0;
    int beat = 0;
    int stall_left = stall_len;
    bit fin = 0;
    bit hold_pend = 0;
    bit poked = 0;
    logic [31:0] hold_val = '0;
    res_q.delete();
    res16_q.delete();
    first_beat_cyc = -1; first_vld_cyc = -1; stall_err = 0; done_cnt = 0;
    a_rdy_seen = 0; busy_seen = 0; timed_out = 0; busy_at_done = 1; vld_at_done = 1;
    start = 1'b1; k_len = KW'(kl); signed_mode = sm;
    @(posedge CLK); #1;
    start = 1'b0;
    while (!fin) begin
      if (busy) busy_seen = 1;
      if (a_rdy) a_rdy_seen = 1;
      if (done) begin
        done_cnt++;
        busy_at_done = busy;
        vld_at_done = out_vld;
        fin = 1;
      end else begin
        if (hold_pend) begin
          if (!out_vld || out_data !== hold_val) stall_err++;
          hold_pend = 0;
        end
        a_vld = 1'b0; a_data = '0; b_data = '0;
        if (beat < kl && (!gaps || (cyc % 2) == 0)) begin
          a_vld = 1'b1;
          for (int i = 0; i < N; i++) begin
            a_data[i*DW +: DW] = ga[beat][i];
            b_data[i*DW +: DW] = gb[beat][i];
          end
        end
        out_rdy = 1'b1;
        if (out_vld && res_q.size() == stall_at && stall_left > 0) begin
          out_rdy = 1'b0;
          stall_left--;
        end
        start = 1'b0;
        if (poke && out_vld && !poked) begin
          start = 1'b1; k_len = '0; poked = 1;
        end
        if (a_vld && a_rdy) begin
          if (first_beat_cyc < 0) first_beat_cyc = cyc;
          beat++;
        end
        if (out_vld) begin
          if (first_vld_cyc < 0) first_vld_cyc = cyc;
          if (out_rdy) begin
            res_q.push_back(out_data);
            res16_q.push_back(out_data16);
          end else begin
            hold_pend = 1;
            hold_val = out_data;
          end
        end
        @(posedge CLK); #1;
        cyc++;
        if (cyc > 3000) begin
          timed_out = 1;
          fin = 1;
        end
      end
    end
    a_vld = 1'b0; start = 1'b0;
    @(posedge CLK); #1;
    done_next = done;
  endtask

  task automatic test_reset();
    #1 RST_N = 1'b0;
    #2;
    n_checks++; if (a_rdy !== 1'b0)    begin n_fail++; $display("FAIL reset_a_rdy got %b want 0", a_rdy); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (out_vld !== 1'b0)  begin n_fail++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (out_data !== '0)   begin n_fail++; $display("FAIL reset_out_data got %0h want 0", out_data); end
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_basic();
    logic [31:0] exp [4] = '{32'd19, 32'd22, 32'd43, 32'd50};
    load_scn1();
    do_job(2, 0, 0, -1, 0, 0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout got timeout want done"); end
    n_checks++; if (res_q.size() != 4) begin n_fail++; $display("FAIL basic_count got %0d want 4", res_q.size()); end
    for (int r = 0; r < 4 && r < res_q.size(); r++) begin
      n_checks++;
      if (res_q[r] !== exp[r]) begin n_fail++; $display("FAIL basic_res%0d got %0d want %0d", r, res_q[r], exp[r]); end
    end
    n_checks++; if (first_vld_cyc - first_beat_cyc != 4) begin n_fail++; $display("FAIL basic_latency got %0d want 4", first_vld_cyc - first_beat_cyc); end
    n_checks++; if (done_cnt != 1 || busy_at_done !== 1'b0 || vld_at_done !== 1'b0) begin
      n_fail++; $display("FAIL basic_done got cnt=%0d busy=%b vld=%b want 1/0/0", done_cnt, busy_at_done, vld_at_done); end
    n_checks++; if (done_next !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b want 0", done_next); end
  endtask

  task automatic test_signed();
    logic [31:0] exp_s [4] = '{32'hFFFFFFF8, 32'd10, 32'd12, 32'hFFFFFFF1};
    logic [31:0] exp_u [4] = '{32'd1016, 32'd63754, 32'd12, 32'd753};
    ga[0][0] = 8'hFE; ga[0][1] = 8'h03; gb[0][0] = 8'h04; gb[0][1] = 8'hFB;
    do_job(1, 1, 0, -1, 0, 0);
    n_checks++; if (res_q.size() != 4) begin n_fail++; $display("FAIL signed_count got %0d want 4", res_q.size()); end
    for (int r = 0; r < 4 && r < res_q.size(); r++) begin
      n_checks++;
      if (res_q[r] !== exp_s[r]) begin n_fail++; $display("FAIL signed_res%0d got %0h want %0h", r, res_q[r], exp_s[r]); end
    end
    do_job(1, 0, 0, -1, 0, 0);
    n_checks++; if (res_q.size() != 4) begin n_fail++; $display("FAIL unsigned_count got %0d want 4", res_q.size()); end
    for (int r = 0; r < 4 && r < res_q.size(); r++) begin
      n_checks++;
      if (res_q[r] !== exp_u[r]) begin n_fail++; $display("FAIL unsigned_res%0d got %0d want %0d", r, res_q[r], exp_u[r]); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp [4] = '{32'd19, 32'd22, 32'd43, 32'd50};
    load_scn1();
    do_job(2, 0, 1, 1, 3, 0);
    n_checks++; if (res_q.size() != 4) begin n_fail++; $display("FAIL stall_count got %0d want 4", res_q.size()); end
    for (int r = 0; r < 4 && r < res_q.size(); r++) begin
      n_checks++;
      if (res_q[r] !== exp[r]) begin n_fail++; $display("FAIL stall_res%0d got %0d want %0d", r, res_q[r], exp[r]); end
    end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_hold got %0d changes want 0", stall_err); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_klen_zero();
    do_job(0, 0, 0, -1, 0, 0);
    n_checks++; if (!busy_seen) begin n_fail++; $display("FAIL k0_busy got 0 want 1"); end
    n_checks++; if (a_rdy_seen) begin n_fail++; $display("FAIL k0_a_rdy got 1 want 0"); end
    n_checks++; if (res_q.size() != 4) begin n_fail++; $display("FAIL k0_count got %0d want 4", res_q.size()); end
    for (int r = 0; r < res_q.size(); r++) begin
      n_checks++;
      if (res_q[r] !== 32'd0) begin n_fail++; $display("FAIL k0_res%0d got %0d want 0", r, res_q[r]); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL k0_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp [4] = '{32'd19, 32'd22, 32'd43, 32'd50};
    load_scn1();
    start = 1'b1; k_len = 8'd2; signed_mode = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0; a_vld = 1'b1;
    a_data = {ga[0][1], ga[0][0]};
    b_data = {gb[0][1], gb[0][0]};
    @(posedge CLK); #1;
    a_vld = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || a_rdy !== 1'b0 || out_vld !== 1'b0 || done !== 1'b0 || out_data !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got busy=%b a_rdy=%b vld=%b done=%b data=%0h want all 0",
                         busy, a_rdy, out_vld, done, out_data); end
    @(posedge CLK); #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle got busy=%b want 0", busy); end
    do_job(2, 0, 0, -1, 0, 1);
    n_checks++; if (res_q.size() != 4) begin n_fail++; $display("FAIL midreset_count got %0d want 4", res_q.size()); end
    for (int r = 0; r < 4 && r < res_q.size(); r++) begin
      n_checks++;
      if (res_q[r] !== exp[r]) begin n_fail++; $display("FAIL midreset_res%0d got %0d want %0d", r, res_q[r], exp[r]); end
    end
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_start_ignored got busy=%b want 0", busy); end
  endtask

  task automatic test_aw16();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin ga[k][i] = 8'hFF; gb[k][i] = 8'hFF; end
    do_job(2, 0, 0, -1, 0, 0);
    n_checks++; if (res16_q.size() != 4) begin n_fail++; $display("FAIL aw16_count got %0d want 4", res16_q.size()); end
    for (int r = 0; r < res16_q.size(); r++) begin
      n_checks++;
      if (res16_q[r] !== 16'd64514) begin n_fail++; $display("FAIL aw16_res%0d got %0d want 64514", r, res16_q[r]); end
      n_checks++;
      if (res_q[r] !== 32'd130050) begin n_fail++; $display("FAIL aw32_res%0d got %0d want 130050", r, res_q[r]); end
    end
  endtask

  task automatic test_random();
    int kl;
    bit sm, gaps;
    logic [31:0] e32;
    logic [15:0] e16;
    for (int t = 0; t < 8; t++) begin
      kl = $urandom_range(1, 10);
      sm = 1'($urandom);
      gaps = 1'($urandom);
      for (int k = 0; k < kl; k++)
        for (int i = 0; i < N; i++) begin ga[k][i] = 8'($urandom); gb[k][i] = 8'($urandom); end
      do_job(kl, sm, gaps, $urandom_range(0, 3), $urandom_range(0, 4), 0);
      n_checks++; if (res_q.size() != 4) begin n_fail++; $display("FAIL rand%0d_count got %0d want 4", t, res_q.size()); end
      for (int r = 0; r < 4 && r < res_q.size(); r++) begin
        e32 = 32'(model(r / N, r % N, kl, sm, 32));
        e16 = 16'(model(r / N, r % N, kl, sm, 16));
        n_checks++;
        if (res_q[r] !== e32) begin n_fail++; $display("FAIL rand%0d_res%0d got %0h want %0h", t, r, res_q[r], e32); end
        n_checks++;
        if (res16_q[r] !== e16) begin n_fail++; $display("FAIL rand%0d_res16_%0d got %0h want %0h", t, r, res16_q[r], e16); end
      end
      n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL rand%0d_hold got %0d want 0", t, stall_err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_stall();
    test_klen_zero();
    test_reset_mid();
    test_aw16();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sa_nd_mac.md
Name: sa_nd_mac

Overview:
- Parametrised output-stationary N×N integer systolic MAC array. Next generation of the fixed 2-D systolic core.
- Computes C = A·B over a streamed inner dimension of runtime length k_len, with signed or unsigned operands.
- Adds a valid/ready operand stream, stall tolerance, a flush phase and a backpressured row-major result drain.
- Sits beside the existing compute cores under the user-project wrapper and is driven from LA/wishbone glue.

Parameters:
- N, 2, array dimension (rows = cols), legal 1..8
- DW, 8, operand width
- AW, 32, accumulator/result width, legal AW >= 2*DW
- KW, 8, width of k_len

Ports:
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- start  in  1  begin job; sampled only in IDLE
- k_len  in  KW  inner-dimension length; sampled with start
- signed_mode  in  1  1 = two's-complement operands; sampled with start
- a_vld  in  1  operand beat valid
- a_rdy  out  1  operand beat accepted when a_vld & a_rdy
- a_data  in  N*DW  row i element A[i][k] at bits [i*DW +: DW]
- b_data  in  N*DW  col j element B[k][j] at bits [j*DW +: DW]
- busy  out  1  high in every state except IDLE
- out_vld  out  1  result valid
- out_rdy  in  1  result consumed when out_vld & out_rdy
- out_data  out  AW  current result C[r][c]
- done  out  1  one-cycle pulse after the last result handshake

Behaviour:
- Reset (async, RST_N=0): state IDLE. All accumulators, skew and pipeline registers cleared. a_rdy, busy, out_vld and done are 0. out_data is 0. Reset mid-job abandons the job; no done pulse.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE -> LOAD when start=1 and k_len != 0. On that edge: latch k_len and signed_mode, clear all accumulators and skew registers, clear the beat counter.
- IDLE -> DRAIN when start=1 and k_len = 0. All results are 0.
- start is ignored outside IDLE.
- LOAD: a_rdy=1. The array advances (global enable) only on a_vld & a_rdy beats. With a_vld=0 the array holds all state (bubble-free).
- LOAD -> FLUSH on the k_len-th accepted beat. If N=1, go directly to DRAIN instead.
- Skew:
  - Row i operand passes through i skew registers, then one PE register per column hop.
  - Col j operand passes through j skew registers, then one register per row hop.
  - Beat k therefore meets at PE(i,j) after i+j enabled cycles.
- FLUSH:
  - Lasts exactly 2N-2 cycles.
  - Enable is forced to 1 and zero operands are injected.
  - a_rdy=0.
  - Transition to DRAIN on the final cycle.
- Arithmetic:
  - Signed mode: sign-extend each operand.
  - Unsigned mode: zero-extend each operand.
  - The 2*DW-bit product is extended to AW; acc += product modulo 2^AW (wraps, no saturation).
- DRAIN:
  - out_vld=1 and out_data = C[r][c].
  - Index order is row-major: 0..N*N-1, C[0][0] first.
  - out_data and out_vld are held stable while out_rdy=0.
  - The index advances on each handshake.
  - After handshake N*N-1: done=1 for one cycle, out_vld=0, state IDLE.
  - A start in that same done cycle is honoured (IDLE is sampled normally).
- busy = (state != IDLE).
- Latency with no stalls: k_len + (2N-2) cycles from the first beat to the first out_vld.

Test Plan:
1. N=2, DW=8, unsigned, k_len=2. Beats a={1,3},b={5,6} then a={2,4},b={7,8} -> out 19,22,43,50 in order, then done pulse, busy=0.
2. Signed, k_len=1, a={0xFE,0x03}, b={0x04,0xFB} -> 0xFFFFFFF8, 10, 12, 0xFFFFFFF1. Same bytes with signed_mode=0 -> 1016, 63754, 12, 753.
3. Scenario 1 with a_vld low every other cycle and out_rdy low for 3 cycles mid-drain -> identical results; out_data stable during stall; no duplicate or dropped result.
4. k_len=0 -> busy rises, four results all 0, done pulse, no a_rdy assertion.
5. RST_N low during LOAD (after beat 1 of scenario 1) -> outputs 0 immediately, state IDLE. A fresh scenario 1 then yields 19,22,43,50. start pulsed during DRAIN is ignored.
6. AW=16, unsigned, k_len=2, all operands 0xFF -> every result 64514 (130050 mod 65536).
